// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep checker: drives every input vector, samples resp, counts mismatches.
// Optional macro TT_SWEEP_GRAY_EN selects Gray-order sweep instead of binary order.
module tt_sweep_checker #(
  parameter int                 N_IN     = 3,
  parameter logic [2**N_IN-1:0] EXP_TT   = 8'hE8,
  parameter int                 STEP_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            resp,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_valid
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [N_IN-1:0] LAST_IDX  = '1;
  localparam logic [7:0]      HOLD_LAST = 8'(STEP_CYC - 1);

  state_t          r_state, w_state_next;
  logic [N_IN-1:0] r_stim, w_stim_next;
  logic            r_busy, w_busy_next;
  logic            r_done, w_done_next;
  logic            r_pass, w_pass_next;
  logic [N_IN:0]   r_err_cnt, w_err_cnt_next;
  logic [N_IN-1:0] r_first_fail, w_first_fail_next;
  logic            r_fail_valid, w_fail_valid_next;
  logic [N_IN-1:0] r_idx, w_idx_next;
  logic [7:0]      r_hold, w_hold_next;
  logic            w_mismatch;
  logic [N_IN:0]   w_err_sat;

  function automatic logic [N_IN-1:0] map_idx(input logic [N_IN-1:0] idx);
`ifdef TT_SWEEP_GRAY_EN
    return idx ^ (idx >> 1);
`else
    return idx;
`endif
  endfunction

  // Mismatch is judged against the vector currently on stim, not the raw index.
  always_comb begin
    w_mismatch = (resp != EXP_TT[r_stim]);
    w_err_sat  = (w_mismatch && (r_err_cnt != '1)) ? r_err_cnt + (N_IN+1)'(1) : r_err_cnt;
  end

  always_comb begin
    w_state_next      = r_state;
    w_stim_next       = r_stim;
    w_busy_next       = r_busy;
    w_done_next       = 1'b0;
    w_pass_next       = r_pass;
    w_err_cnt_next    = r_err_cnt;
    w_first_fail_next = r_first_fail;
    w_fail_valid_next = r_fail_valid;
    w_idx_next        = r_idx;
    w_hold_next       = r_hold;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next      = RUN;
          w_err_cnt_next    = '0;
          w_fail_valid_next = 1'b0;
          w_pass_next       = 1'b0;
          w_idx_next        = '0;
          w_hold_next       = '0;
          w_stim_next       = map_idx('0);
          w_busy_next       = 1'b1;
        end
      end
      RUN: begin
        if (r_hold == HOLD_LAST) begin
          w_err_cnt_next = w_err_sat;
          if (w_mismatch && !r_fail_valid) begin
            w_first_fail_next = r_stim;
            w_fail_valid_next = 1'b1;
          end
          if (r_idx == LAST_IDX) begin
            w_state_next = FIN;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_pass_next  = (w_err_sat == '0);
          end else begin
            w_idx_next  = r_idx + N_IN'(1);
            w_hold_next = '0;
            w_stim_next = map_idx(r_idx + N_IN'(1));
          end
        end else begin
          w_hold_next = r_hold + 8'd1;
        end
      end
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_stim       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
      r_first_fail <= '0;
      r_fail_valid <= 1'b0;
      r_idx        <= '0;
      r_hold       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_stim       <= w_stim_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_pass       <= w_pass_next;
      r_err_cnt    <= w_err_cnt_next;
      r_first_fail <= w_first_fail_next;
      r_fail_valid <= w_fail_valid_next;
      r_idx        <= w_idx_next;
      r_hold       <= w_hold_next;
    end
  end

  assign stim       = r_stim;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err_cnt;
  assign first_fail = r_first_fail;
  assign fail_valid = r_fail_valid;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Self-checking bench for tt_sweep_checker: table rows, random truth tables vs a sweep model,
// mid-sweep start, reset abort, and a STEP_CYC=3 instance.
module tb_tt_sweep_checker;

  logic       clk;
  logic       rst_n;
  logic [1:0] start_v;
  logic [1:0] resp_v;
  logic [2:0] stim_a [2];
  logic [1:0] busy_v, done_v, pass_v, fv_v;
  logic [3:0] err_a [2];
  logic [2:0] ff_a [2];

  int         checks = 0;
  int         errors = 0;
  int         order [8];
  int         ff_prev [2];
  logic [7:0] exp_tt = 8'hE8;

  tt_sweep_checker #(.N_IN(3), .EXP_TT(8'hE8), .STEP_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .resp(resp_v[0]),
    .stim(stim_a[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_cnt(err_a[0]), .first_fail(ff_a[0]), .fail_valid(fv_v[0])
  );

  tt_sweep_checker #(.N_IN(3), .EXP_TT(8'hE8), .STEP_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .resp(resp_v[1]),
    .stim(stim_a[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_cnt(err_a[1]), .first_fail(ff_a[1]), .fail_valid(fv_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tt;
    int         err;
    int         ff;
    bit         fv;
    string      name;
  } row_t;

  row_t rows [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mismatch count and first failing vector, walking vectors in sweep order.
  task automatic model(input logic [7:0] tt, output int errs, output int ff, output bit fv);
    errs = 0; ff = 0; fv = 0;
    for (int i = 0; i < 8; i++) begin
      if (tt[order[i]] != exp_tt[order[i]]) begin
        if (!fv) begin ff = order[i]; fv = 1; end
        errs++;
      end
    end
  endtask

  task automatic chk_all_zero(input int w, input string tag);
    chk({tag, "_stim"}, 32'(stim_a[w]), 0);
    chk({tag, "_busy"}, 32'(busy_v[w]), 0);
    chk({tag, "_done"}, 32'(done_v[w]), 0);
    chk({tag, "_pass"}, 32'(pass_v[w]), 0);
    chk({tag, "_err"},  32'(err_a[w]),  0);
    chk({tag, "_ff"},   32'(ff_a[w]),   0);
    chk({tag, "_fv"},   32'(fv_v[w]),   0);
  endtask

  // resp follows truth table tt of the stim currently driven; start may be re-pulsed at restart_cyc.
  task automatic run_sweep(input int w, input logic [7:0] tt, input int exp_err, input int exp_ff,
                           input bit exp_fv, input int restart_cyc, input string name);
    int step;
    int ffx;
    step = (w == 0) ? 1 : 3;
    ffx  = exp_fv ? exp_ff : ff_prev[w];
    @(negedge clk);
    resp_v[w]  = tt[stim_a[w]];
    start_v[w] = 1'b1;
    @(posedge clk);
    #1 start_v[w] = 1'b0;
    for (int c = 1; c <= 8 * step + 1; c++) begin
      @(negedge clk);
      start_v[w] = (c == restart_cyc);
      resp_v[w]  = tt[stim_a[w]];
      if (c <= 8 * step) begin
        chk({name, "_busy"}, 32'(busy_v[w]), 1);
        chk({name, "_done_early"}, 32'(done_v[w]), 0);
        chk({name, "_stim"}, 32'(stim_a[w]), 32'(order[(c - 1) / step]));
      end else begin
        chk({name, "_done"}, 32'(done_v[w]), 1);
        chk({name, "_busy_fin"}, 32'(busy_v[w]), 0);
        chk({name, "_err_cnt"}, 32'(err_a[w]), 32'(exp_err));
        chk({name, "_first_fail"}, 32'(ff_a[w]), 32'(ffx));
        chk({name, "_fail_valid"}, 32'(fv_v[w]), 32'(exp_fv));
        chk({name, "_pass"}, 32'(pass_v[w]), 32'(exp_err == 0));
      end
    end
    @(negedge clk);
    start_v[w] = 1'b0;
    chk({name, "_done_once"}, 32'(done_v[w]), 0);
    chk({name, "_idle_busy"}, 32'(busy_v[w]), 0);
    chk({name, "_idle_stim"}, 32'(stim_a[w]), 32'(order[7]));
    chk({name, "_idle_pass"}, 32'(pass_v[w]), 32'(exp_err == 0));
    ff_prev[w] = ffx;
    $display("sweep %s dut%0d tt=%h err_cnt=%0d first_fail=%0d pass=%0b",
             name, w, tt, err_a[w], ff_a[w], pass_v[w]);
  endtask

  initial begin
    int e, f, pos4, pos5;
    bit v;
    logic [7:0] tt;

    for (int i = 0; i < 8; i++) begin
`ifdef TT_SWEEP_GRAY_EN
      order[i] = i ^ (i >> 1);
`else
      order[i] = i;
`endif
    end
    for (int i = 0; i < 8; i++) begin
      if (order[i] == 4) pos4 = i;
      if (order[i] == 5) pos5 = i;
    end
    ff_prev[0] = 0; ff_prev[1] = 0;

    rows[0] = '{tt: 8'hE8, err: 0, ff: 0, fv: 0, name: "majority"};
    rows[1] = '{tt: 8'h00, err: 4, ff: 3, fv: 1, name: "stuck0"};
    rows[2] = '{tt: 8'hFF, err: 4, ff: 0, fv: 1, name: "stuck1"};
    rows[3] = '{tt: 8'h17, err: 8, ff: 0, fv: 1, name: "inverted"};
    rows[4] = '{tt: 8'h68, err: 1, ff: 7, fv: 1, name: "flip7"};
    rows[5] = '{tt: 8'hE9, err: 1, ff: 0, fv: 1, name: "flip0"};
    rows[6] = '{tt: 8'hF8, err: 1, ff: 4, fv: 1, name: "flip4"};

    rst_n = 1'b0; start_v = '0; resp_v = '0;
    repeat (3) @(negedge clk);
    chk_all_zero(0, "reset1");
    chk_all_zero(1, "reset3");
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 7; r++)
      run_sweep(0, rows[r].tt, rows[r].err, rows[r].ff, rows[r].fv, 0, rows[r].name);

    // Majority after stuck0 etc: first_fail held from previous sweep, fail_valid cleared.
    run_sweep(0, 8'hE8, 0, 0, 0, 0, "majority_hold");

    for (int n = 0; n < 8; n++) begin
      tt = 8'($urandom);
      model(tt, e, f, v);
      run_sweep(0, tt, e, f, v, 0, "random1");
    end

    run_sweep(1, 8'hE8, 0, 0, 0, 0, "step3_majority");
    run_sweep(1, 8'h00, 4, 3, 1, 0, "step3_stuck0");
    for (int n = 0; n < 2; n++) begin
      tt = 8'($urandom);
      model(tt, e, f, v);
      run_sweep(1, tt, e, f, v, 0, "random3");
    end

    // Start re-pulsed while stim=4 must be ignored.
    run_sweep(0, 8'hE8, 0, 0, 0, pos4 + 1, "restart_ignored");

    // Reset asserted while stim=5 aborts the sweep without a done pulse.
    @(negedge clk);
    resp_v[0]  = exp_tt[stim_a[0]];
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    for (int c = 1; c <= pos5 + 1; c++) begin
      @(negedge clk);
      resp_v[0] = exp_tt[stim_a[0]];
    end
    chk("abort_stim", 32'(stim_a[0]), 5);
    rst_n = 1'b0;
    #1;
    chk_all_zero(0, "abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done_v[0]), 0);
      chk("abort_no_busy", 32'(busy_v[0]), 0);
    end
    ff_prev[0] = 0; ff_prev[1] = 0;
    $display("sweep abort dut0 reset at stim=5");
    run_sweep(0, 8'h00, 4, 3, 1, 0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_sweep_checker.md
TT_SWEEP_CHECKER -- requirements
Module: tt_sweep_checker

Interface
REQ-001 Parameter N_IN, default 3: number of DUT inputs driven, legal range 1..8.
REQ-002 Parameter EXP_TT, default 8'hE8: expected truth table, width 2**N_IN bits; bit k is the expected response for input vector k.
REQ-003 Parameter STEP_CYC, default 1: clock cycles each vector is held, legal range 1..255.
REQ-004 clk  input  1  single clock, rising-edge active.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  sweep request, sampled on rising clk.
REQ-007 resp  input  1  DUT output under check.
REQ-008 stim  output  N_IN  vector driven to DUT inputs.
REQ-009 busy  output  1  high while a sweep is running.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 pass  output  1  result of the last completed sweep; high when err_cnt is 0.
REQ-012 err_cnt  output  N_IN+1  mismatch count of the current or last sweep.
REQ-013 first_fail  output  N_IN  vector value (stim) of the first mismatch.
REQ-014 fail_valid  output  1  high once first_fail holds a captured vector.

Function
REQ-015 FSM states: IDLE, RUN, FIN; all outputs are registered.
REQ-016 IDLE, start=1: clear err_cnt, fail_valid, pass, vector index and hold counter; go to RUN on the next edge.
REQ-017 RUN: busy=1; stim = map(index), where map is identity unless REQ-028 applies.
REQ-018 RUN: the hold counter runs 0..STEP_CYC-1; resp is sampled at the edge where hold = STEP_CYC-1.
REQ-019 Sample mismatch: resp != EXP_TT[stim] is a mismatch.
  - err_cnt increments, saturating at all-ones.
  - On the first mismatch only, first_fail <= stim and fail_valid <= 1.
REQ-020 Sample step: if index = 2**N_IN-1, go to FIN; otherwise index++ and hold <= 0. Index never wraps inside a sweep.
REQ-021 FIN: done=1 for exactly one cycle, busy=0, pass <= (err_cnt after the final sample == 0); then return to IDLE.
REQ-022 Latency: start accepted at edge k gives done high during cycle k+1+(2**N_IN)*STEP_CYC.
REQ-023 start while in RUN or FIN is ignored; there is no restart and no queuing.
REQ-024 In IDLE, stim, err_cnt, pass, first_fail and fail_valid hold their last values until the next accepted start.
REQ-025 The first and last vectors are checked like any other; the sweep covers exactly 2**N_IN samples.

Reset
REQ-026 rst_n=0 immediately forces:
  - state IDLE;
  - stim, busy, done, pass, err_cnt, first_fail and fail_valid all 0;
  - index and hold counter 0.
REQ-027 Reset during RUN aborts the sweep with no done pulse; the first start after rst_n rises begins a fresh sweep.

Configuration
REQ-028 Macro TT_SWEEP_GRAY_EN.
  - Defined: map(index) = index ^ (index >> 1), Gray-order sweep; expected bit is EXP_TT[stim].
  - Undefined: map(index) = index, binary order.
  - Count, latency and pass semantics are identical in both modes.

Verification (N_IN=3, EXP_TT=8'hE8, STEP_CYC=1 unless stated)
REQ-029 resp from a correct majority model -> 8 samples, done at k+9, pass=1, err_cnt=0, fail_valid=0.
REQ-030 resp stuck at 0 -> err_cnt=4, first_fail=3, fail_valid=1, pass=0; with TT_SWEEP_GRAY_EN (order 0,1,3,2,6,7,5,4) first_fail=3.
REQ-031 resp stuck at 1 -> err_cnt=4, first_fail=0, pass=0.
REQ-032 STEP_CYC=3, correct model -> each stim value held 3 cycles, done at k+25, pass=1.
REQ-033 start pulsed again at stim=4 -> ignored, single done at k+9; then rst_n low at stim=5 -> all outputs 0, no done, and a new start gives a full sweep.
